rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter that shares one one-hot-select N:1 mux between NUM_REQ requesters.

---
 rtl/arb_pkg.sv | 50 +++++
 rtl/rr_mux_arbiter_onehot_mux.sv | 27 ++
 rtl/rr_mux_arbiter.sv | 151 +++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, width helpers and round-robin pick function
//
// Purpose:
//   Common definitions for the round-robin mux arbiter. Holds the FSM state
//   type, the widest index/counter widths the arbiter supports, and the
//   combinational round-robin winner search used by the top level.
//
// Contents:
//   arb_state_t  IDLE / BUSY state encoding
//   MAX_REQ      largest requester count supported by rr_pick
//   PTR_W        index width able to address MAX_REQ requesters
//   CNT_W        counter width able to count the largest legal hold limit
//   rr_pick()    one-hot winner of a circular scan starting at ptr
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);
  localparam int CNT_W   = $clog2(256);

  // Scans req starting at ptr and wrapping modulo n; returns the first set
  // bit as a one-hot vector, or all zeros if nothing is requesting. Bits at
  // or above n are never returned, so callers may pad req with zeros.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] win;
    logic               found;
    logic [PTR_W-1:0]   idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = PTR_W'((int'(ptr) + i) % n);
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_onehot_mux.sv
// rtl/rr_mux_arbiter_onehot_mux.sv - combinational AND-OR one-hot select
//
// Purpose:
//   N:1 data selector driven by a one-hot select. Each lane is masked by its
//   select bit and the results are ORed, so an all-zero select yields zero.
//
// Ports:
//   sel   in   NUM_REQ         one-hot (or zero) lane select
//   data  in   NUM_REQ*DATA_W  packed lanes; lane k = data[k*DATA_W +: DATA_W]
//   y     out  DATA_W          selected lane, 0 when sel is all zeros
module onehot_mux #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1
) (
  input  logic [NUM_REQ-1:0]        sel,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [DATA_W-1:0]         y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      y = y | (data[k*DATA_W +: DATA_W] & {DATA_W{sel[k]}});
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter sharing one one-hot-select mux
//
// Purpose:
//   Grants one of NUM_REQ requesters at a time, holds the grant until the
//   grantee releases, withdraws, or hits the MAX_HOLD limit, then spends one
//   dead IDLE cycle before re-arbitrating. The registered grant doubles as
//   the select of the shared mux that produces y_o.
//
// Ports:
//   clk        in   1               rising-edge clock
//   reset_n    in   1               asynchronous active-low reset
//   req_i      in   NUM_REQ         level-sensitive request per requester
//   data_i     in   NUM_REQ*DATA_W  packed requester data lanes
//   rel_i      in   1               current grantee releases the resource
//   gnt_o      out  NUM_REQ         registered one-hot grant / mux select
//   valid_o    out  1               registered, high while a grant is held
//   y_o        out  DATA_W          lane selected by gnt_o, 0 with no grant
//   timeout_o  out  1               registered pulse on a forced release
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic                      rel_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         y_o,
  output logic                      timeout_o
);

  localparam int PTR_BITS = $clog2(NUM_REQ);
  localparam int CNT_BITS = $clog2(MAX_HOLD);
  localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(MAX_HOLD - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                valid_q, valid_d;
  logic                tmo_q, tmo_d;
  logic [PTR_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [MAX_REQ-1:0]  req_ext;
  logic [MAX_REQ-1:0]  pick_ext;
  logic [NUM_REQ-1:0]  pick;
  logic [PTR_BITS-1:0] ptr_after_pick;
  logic                unused_pick;

  logic                do_rel;
  logic                withdrew;
  logic                hit_limit;

  // The package search works on the widest supported vector; pad with zeros.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req_i;
  end

  assign pick_ext    = rr_pick(req_ext, PTR_W'(ptr_q), NUM_REQ);
  assign pick        = pick_ext[NUM_REQ-1:0];
  assign unused_pick = ^pick_ext;

  // Pointer moves to the slot just past the winner so it has lowest priority
  // at the next arbitration.
  always_comb begin
    ptr_after_pick = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        if (k == NUM_REQ - 1) ptr_after_pick = '0;
        else                  ptr_after_pick = PTR_BITS'(k + 1);
      end
    end
  end

  assign do_rel    = rel_i;
  assign withdrew  = ~|(req_i & gnt_q);
  assign hit_limit = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d   = pick;
          valid_d = 1'b1;
          cnt_d   = '0;
          ptr_d   = ptr_after_pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (do_rel || withdrew || hit_limit) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
          // Only flag a forced release when the grantee had not let go anyway.
          tmo_d   = hit_limit && !do_rel && !withdrew;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign valid_o   = valid_q;
  assign timeout_o = tmo_q;

  onehot_mux #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) u_mux (
    .sel  (gnt_q),
    .data (data_i),
    .y    (y_o)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int MH = 8;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_i   = '0;
  logic [NR*DW-1:0] data_i  = 16'h9A5C;
  logic             rel_i   = 1'b0;
  logic [NR-1:0]    gnt_o;
  logic             valid_o;
  logic [DW-1:0]    y_o;
  logic             timeout_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NR-1:0] gnt;
    logic          tmo;
  } exp_t;

  exp_t sb[$];

  rr_mux_arbiter #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_i),
    .data_i    (data_i),
    .rel_i     (rel_i),
    .gnt_o     (gnt_o),
    .valid_o   (valid_o),
    .y_o       (y_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: advances on each rising edge and queues what the
  // registered outputs must show for the following cycle.
  initial begin
    int   owner;
    int   ptr;
    int   held;
    exp_t e;
    logic t;
    owner = -1;
    ptr   = 0;
    held  = 0;
    forever begin
      @(posedge clk);
      t = 1'b0;
      if (!reset_n) begin
        owner = -1;
        ptr   = 0;
        held  = 0;
      end else if (owner < 0) begin
        for (int i = 0; i < NR; i++) begin
          int k;
          k = (ptr + i) % NR;
          if (owner < 0 && req_i[k]) owner = k;
        end
        if (owner >= 0) begin
          held = 0;
          ptr  = (owner + 1) % NR;
        end
      end else if (rel_i || !req_i[owner] || held == MH - 1) begin
        t     = !rel_i && req_i[owner];
        owner = -1;
      end else begin
        held++;
      end
      e.gnt = (owner >= 0) ? NR'(1 << owner) : '0;
      e.tmo = t;
      sb.push_back(e);
    end
  end

  // Scoreboard checker on the falling edge, away from the active edge.
  initial begin
    exp_t          e;
    logic [DW-1:0] ye;
    forever begin
      @(negedge clk);
      check("onehot", 32'($onehot0(gnt_o)), 32'd1);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ye = '0;
        for (int k = 0; k < NR; k++)
          if (e.gnt[k]) ye = ye | data_i[k*DW +: DW];
        check("sb_gnt", 32'(gnt_o), 32'(e.gnt));
        check("sb_valid", 32'(valid_o), 32'(|e.gnt));
        check("sb_tmo", 32'(timeout_o), 32'(e.tmo));
        check("sb_y", 32'(y_o), 32'(ye));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [NR-1:0] order[$];
    logic [NR-1:0] prev;
    logic [NR-1:0] exp_order[5];
    int            b2b;
    int            gcnt;
    int            tcnt;

    // reset state
    tick(2);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // 1: single request, one-cycle grant latency, lane 2 on y_o
    req_i = 4'b0100;
    tick(1);
    check("s1_gnt", 32'(gnt_o), 32'h4);
    check("s1_valid", 32'(valid_o), 32'd1);
    check("s1_y", 32'(y_o), 32'hA);
    req_i = '0;
    tick(2);

    // 2: all requesting, rel pulsed per grant -> rotating order, dead cycles
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    req_i = 4'b1111;
    prev  = '0;
    b2b   = 0;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      tick(1);
      if (gnt_o != 0 && prev == 0) order.push_back(gnt_o);
      if (gnt_o != 0 && prev != 0) b2b++;
      rel_i = (gnt_o != 0);
      prev  = gnt_o;
    end
    rel_i = 1'b0;
    req_i = '0;
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    exp_order[4] = 4'b0001;
    for (int i = 0; i < 5; i++)
      check($sformatf("s2_order%0d", i), 32'((i < order.size()) ? order[i] : 4'b0), 32'(exp_order[i]));
    check("s2_backtoback", 32'(b2b), 32'd0);
    tick(2);

    // 3: held request, no release -> 8 granted cycles then a timeout pulse
    req_i = 4'b0010;
    tick(1);
    gcnt = 0;
    tcnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (gnt_o == 4'b0010) gcnt++;
      if (timeout_o) tcnt++;
      if (i == 8) check("s3_gnt_off", 32'(gnt_o), 32'd0);
      tick(1);
    end
    check("s3_hold_cycles", 32'(gcnt), 32'd8);
    check("s3_tmo_pulses", 32'(tcnt), 32'd1);
    req_i = '0;
    tick(3);

    // 4a: release coinciding with the last hold cycle -> no timeout
    req_i = 4'b0001;
    tick(1);
    check("s4_gnt", 32'(gnt_o), 32'h1);
    tick(7);
    rel_i = 1'b1;
    tick(1);
    rel_i = 1'b0;
    check("s4_rel_gnt", 32'(gnt_o), 32'd0);
    check("s4_rel_tmo", 32'(timeout_o), 32'd0);
    req_i = '0;
    tick(2);

    // 4b: grantee withdraws mid-hold
    req_i = 4'b0100;
    tick(3);
    check("s4_wd_held", 32'(gnt_o), 32'h4);
    req_i = '0;
    tick(1);
    check("s4_wd_gnt", 32'(gnt_o), 32'd0);
    check("s4_wd_tmo", 32'(timeout_o), 32'd0);
    tick(2);

    // 5: asynchronous reset mid-grant, then pointer restarts at 0
    req_i = 4'b0100;
    tick(3);
    check("s5_pre", 32'(gnt_o), 32'h4);
    #2 reset_n = 1'b0;
    #1;
    check("s5_async_gnt", 32'(gnt_o), 32'd0);
    check("s5_async_valid", 32'(valid_o), 32'd0);
    check("s5_async_y", 32'(y_o), 32'd0);
    req_i = '0;
    tick(2);
    reset_n = 1'b1;
    req_i   = 4'b1010;
    tick(1);
    check("s5_ptr_rst", 32'(gnt_o), 32'h2);
    req_i = '0;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    req_i   = 4'b1000;
    tick(1);
    check("s5_gnt1000", 32'(gnt_o), 32'h8);
    req_i = '0;
    tick(2);

    // 6: no requests while data toggles
    for (int i = 0; i < 6; i++) begin
      data_i = 16'($urandom);
      tick(1);
      check("s6_y", 32'(y_o), 32'd0);
      check("s6_valid", 32'(valid_o), 32'd0);
      check("s6_gnt", 32'(gnt_o), 32'd0);
    end
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
